// File: rtl/jtag_tap_pkg.sv
// JTAG TAP responder shared types: 1149.1 state codes,
// next-state function and default opcodes.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    EX2DR   = 4'h0,
    EX1DR   = 4'h1,
    SHDR    = 4'h2,
    PAUSEDR = 4'h3,
    SELIR   = 4'h4,
    UPDDR   = 4'h5,
    CAPDR   = 4'h6,
    SELDR   = 4'h7,
    EX2IR   = 4'h8,
    EX1IR   = 4'h9,
    SHIR    = 4'hA,
    PAUSEIR = 4'hB,
    RTI     = 4'hC,
    UPDIR   = 4'hD,
    CAPIR   = 4'hE,
    TLR     = 4'hF
  } tap_state_e;

  localparam logic [3:0]  OP_IDCODE  = 4'h1;
  localparam logic [3:0]  OP_USER    = 4'h8;
  localparam logic [31:0] IDCODE_DEF = 32'h1BB0_0001;

  function automatic tap_state_e tap_next(
    input tap_state_e s,
    input logic       tms
  );
    tap_state_e n;
    case (s)
      TLR:     n = tms ? TLR     : RTI;
      RTI:     n = tms ? SELDR   : RTI;
      SELDR:   n = tms ? SELIR   : CAPDR;
      CAPDR:   n = tms ? EX1DR   : SHDR;
      SHDR:    n = tms ? EX1DR   : SHDR;
      EX1DR:   n = tms ? UPDDR   : PAUSEDR;
      PAUSEDR: n = tms ? EX2DR   : PAUSEDR;
      EX2DR:   n = tms ? UPDDR   : SHDR;
      UPDDR:   n = tms ? SELDR   : RTI;
      SELIR:   n = tms ? TLR     : CAPIR;
      CAPIR:   n = tms ? EX1IR   : SHIR;
      SHIR:    n = tms ? EX1IR   : SHIR;
      EX1IR:   n = tms ? UPDIR   : PAUSEIR;
      PAUSEIR: n = tms ? EX2IR   : PAUSEIR;
      EX2IR:   n = tms ? UPDIR   : SHIR;
      UPDIR:   n = tms ? SELDR   : RTI;
      default: n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_responder_sync.sv
// Two-flop synchronizer for the JTAG pins; the edge input
// gets a history flop and one-CLK rise/fall pulses.
module jtag_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         edge_i,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] lvl_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [1:0]   e_q;
  logic         h_q;
  logic [W-1:0] l1_q;
  logic [W-1:0] l2_q;

  // synchronize all pins with identical delay; keep TCK history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      e_q  <= '0;
      h_q  <= 1'b0;
      l1_q <= '0;
      l2_q <= '0;
    end else begin
      e_q  <= {e_q[0], edge_i};
      h_q  <= e_q[1];
      l1_q <= lvl_i;
      l2_q <= l1_q;
    end
  end

  assign lvl_o  = l2_q;
  assign rise_o = e_q[1] & ~h_q;
  assign fall_o = ~e_q[1] & h_q;

endmodule

// File: rtl/jtag_tap_responder.sv
// JTAG TAP responder: oversampled TAP FSM, IR/DR shift, TDO.
// Optional nTRST pin when NTRST_EN is defined.
module jtag_tap_responder
  import jtag_tap_pkg::*;
#(
  parameter int              IR_W       = 4,
  parameter int              USER_W     = 16,
  parameter logic [31:0]     IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_W-1:0] IR_IDCODE  = IR_W'(OP_IDCODE),
  parameter logic [IR_W-1:0] IR_USER    = IR_W'(OP_USER)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              TCK_I,
  input  logic              TMS_I,
  input  logic              TDI_I,
`ifdef NTRST_EN
  input  logic              NTRST_I,
`endif
  output logic              TDO_O,
  output logic              TDO_OE,
  input  logic [USER_W-1:0] USER_CAP,
  output logic [USER_W-1:0] USER_UPD,
  output logic              USER_STB,
  output logic [3:0]        TAP_STATE,
  output logic [IR_W-1:0]   IR_OUT
);

  logic [1:0]        pin_s;
  logic              tck_rise;
  logic              tck_fall;
  logic              tms_s;
  logic              tdi_s;
  logic              trst_n;

  tap_state_e        state_q;
  tap_state_e        state_d;
  logic [IR_W-1:0]   ir_q;
  logic [IR_W-1:0]   ir_sh_q;
  logic [31:0]       id_sh_q;
  logic [USER_W-1:0] usr_sh_q;
  logic              byp_q;
  logic [USER_W-1:0] usr_upd_q;
  logic              usr_stb_q;
  logic              tdo_q;
  logic              tdo_oe_q;
  logic              sel_id;
  logic              sel_usr;
  logic              in_shift;
  logic              sh_lsb;

  jtag_sync_edge #(
    .W(2)
  ) u_sync (
    .clk_i (CLK),
    .rst_i (RST),
    .edge_i(TCK_I),
    .lvl_i ({TDI_I, TMS_I}),
    .lvl_o (pin_s),
    .rise_o(tck_rise),
    .fall_o(tck_fall)
  );

  assign tms_s = pin_s[0];
  assign tdi_s = pin_s[1];

`ifdef NTRST_EN
  logic [1:0] trst_q;

  // two-flop synchronizer for the asynchronous nTRST pin
  always_ff @(posedge CLK) begin
    if (RST) trst_q <= 2'b00;
    else     trst_q <= {trst_q[0], NTRST_I};
  end

  assign trst_n = trst_q[1];
`else
  assign trst_n = 1'b1;
`endif

  assign state_d  = tap_next(state_q, tms_s);
  assign sel_id   = (ir_q == IR_IDCODE);
  assign sel_usr  = (ir_q == IR_USER);
  assign in_shift = (state_q == SHIR) ||
                    (state_q == SHDR);

  // LSB of whichever shift register is on the scan path
  always_comb begin
    sh_lsb = byp_q;
    if (state_q == SHIR) sh_lsb = ir_sh_q[0];
    else if (sel_id)     sh_lsb = id_sh_q[0];
    else if (sel_usr)    sh_lsb = usr_sh_q[0];
  end

  // TAP FSM with capture/shift/update and registered TDO
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= TLR;
      ir_q      <= IR_IDCODE;
      ir_sh_q   <= '0;
      id_sh_q   <= '0;
      usr_sh_q  <= '0;
      byp_q     <= 1'b0;
      usr_upd_q <= '0;
      usr_stb_q <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_oe_q  <= 1'b0;
    end else begin
      usr_stb_q <= 1'b0;
      if (!trst_n) begin
        state_q  <= TLR;
        ir_q     <= IR_IDCODE;
        tdo_q    <= 1'b0;
        tdo_oe_q <= 1'b0;
      end else begin
        if (tck_rise) begin
          state_q <= state_d;
          case (state_q)
            CAPIR: ir_sh_q <= IR_W'(1);
            SHIR:  ir_sh_q <= {tdi_s, ir_sh_q[IR_W-1:1]};
            UPDIR: ir_q    <= ir_sh_q;
            CAPDR: begin
              if (sel_id)       id_sh_q  <= IDCODE_VAL;
              else if (sel_usr) usr_sh_q <= USER_CAP;
              else              byp_q    <= 1'b0;
            end
            SHDR: begin
              if (sel_id)
                id_sh_q <= {tdi_s, id_sh_q[31:1]};
              else if (sel_usr)
                usr_sh_q <= {tdi_s, usr_sh_q[USER_W-1:1]};
              else
                byp_q <= tdi_s;
            end
            UPDDR: begin
              if (sel_usr) begin
                usr_upd_q <= usr_sh_q;
                usr_stb_q <= 1'b1;
              end
            end
            default: ;
          endcase
          if (state_d == TLR) ir_q <= IR_IDCODE;
        end
        if (tck_fall) begin
          tdo_oe_q <= in_shift;
          tdo_q    <= in_shift & sh_lsb;
        end
      end
    end
  end

  assign TDO_O     = tdo_q;
  assign TDO_OE    = tdo_oe_q;
  assign USER_UPD  = usr_upd_q;
  assign USER_STB  = usr_stb_q;
  assign TAP_STATE = trst_n ? state_q : TLR;
  assign IR_OUT    = trst_n ? ir_q : IR_IDCODE;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Self-checking bench for jtag_tap_responder: scan sequences
// driven on the pins, expected TDO bits kept in a scoreboard.
module tb_jtag_tap_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        TCK_I = 1'b0;
  logic        TMS_I = 1'b1;
  logic        TDI_I = 1'b0;
`ifdef NTRST_EN
  logic        NTRST_I = 1'b1;
`endif
  logic        TDO_O;
  logic        TDO_OE;
  logic [15:0] USER_CAP = 16'h0;
  logic [15:0] USER_UPD;
  logic        USER_STB;
  logic [3:0]  TAP_STATE;
  logic [3:0]  IR_OUT;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;
  logic exp_q[$];

  localparam logic [3:0] S_TLR = 4'hF;
  localparam logic [3:0] S_RTI = 4'hC;
  localparam logic [3:0] S_SHDR = 4'h2;
  localparam logic [3:0] S_PDR = 4'h3;

  jtag_tap_responder dut (
    .CLK      (CLK),
    .RST      (RST),
    .TCK_I    (TCK_I),
    .TMS_I    (TMS_I),
    .TDI_I    (TDI_I),
`ifdef NTRST_EN
    .NTRST_I  (NTRST_I),
`endif
    .TDO_O    (TDO_O),
    .TDO_OE   (TDO_OE),
    .USER_CAP (USER_CAP),
    .USER_UPD (USER_UPD),
    .USER_STB (USER_STB),
    .TAP_STATE(TAP_STATE),
    .IR_OUT   (IR_OUT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (USER_STB) stb_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tck(input logic tms, input logic tdi,
                     output logic tdo, output logic oe);
    TMS_I = tms;
    TDI_I = tdi;
    repeat (2) @(negedge CLK);
    TCK_I = 1'b1;
    repeat (6) @(negedge CLK);
    TCK_I = 1'b0;
    repeat (6) @(negedge CLK);
    tdo = TDO_O;
    oe  = TDO_OE;
  endtask

  // RTI -> scan n bits -> update -> RTI
  task automatic scan(input bit ir, input int n,
                      input logic [31:0] din,
                      output logic [31:0] dout,
                      output logic [31:0] oe);
    logic t, o;
    dout = '0;
    oe   = '0;
    tck(1'b1, 1'b0, t, o);
    if (ir) tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    for (int i = 0; i < n; i++) begin
      dout[i] = t;
      oe[i]   = o;
      tck(i == n - 1, din[i], t, o);
    end
    tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
  endtask

  task automatic test_reset;
    logic t, o;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (TAP_STATE !== S_TLR || IR_OUT !== 4'h1) begin
      n_err++;
      $display("FAIL rst_state: got %h/%h expected f/1",
               TAP_STATE, IR_OUT);
    end
    n_cmp++;
    if ({TDO_O, TDO_OE, USER_STB} !== 3'b000 ||
        USER_UPD !== 16'h0) begin
      n_err++;
      $display("FAIL rst_out: got %b%b%b %h expected 000 0",
               TDO_O, TDO_OE, USER_STB, USER_UPD);
    end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    repeat (5) tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    n_cmp++;
    if (TAP_STATE !== S_RTI || IR_OUT !== 4'h1 ||
        TDO_OE !== 1'b0) begin
      n_err++;
      $display("FAIL rti: got %h/%h/%b expected c/1/0",
               TAP_STATE, IR_OUT, TDO_OE);
    end
  endtask

  task automatic test_idcode;
    logic [31:0] d, oe;
    logic [31:0] idv = 32'h1BB0_0001;
    for (int i = 0; i < 32; i++) exp_q.push_back(idv[i]);
    scan(1'b0, 32, 32'h0, d, oe);
    for (int i = 0; i < 32; i++) begin
      logic e = exp_q.pop_front();
      n_cmp++;
      if (d[i] !== e) begin
        n_err++;
        $display("FAIL idcode_bit%0d: got %b expected %b",
                 i, d[i], e);
      end
    end
    n_cmp++;
    if (oe !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL idcode_oe: got %h expected ffffffff", oe);
    end
    n_cmp++;
    if (TDO_OE !== 1'b0 || TAP_STATE !== S_RTI) begin
      n_err++;
      $display("FAIL idcode_end: got %b/%h expected 0/c",
               TDO_OE, TAP_STATE);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] d, oe;
    logic [3:0] ev = 4'b1010;
    scan(1'b1, 4, 32'hF, d, oe);
    n_cmp++;
    if (IR_OUT !== 4'hF) begin
      n_err++;
      $display("FAIL byp_ir: got %h expected f", IR_OUT);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(ev[i]);
    scan(1'b0, 4, 32'b1101, d, oe);
    for (int i = 0; i < 4; i++) begin
      logic e = exp_q.pop_front();
      n_cmp++;
      if (d[i] !== e) begin
        n_err++;
        $display("FAIL byp_bit%0d: got %b expected %b",
                 i, d[i], e);
      end
    end
  endtask

  task automatic test_ir_capture;
    logic [31:0] d, oe;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    scan(1'b1, 4, 32'hA, d, oe);
    for (int i = 0; i < 2; i++) begin
      logic e = exp_q.pop_front();
      n_cmp++;
      if (d[i] !== e) begin
        n_err++;
        $display("FAIL ircap_bit%0d: got %b expected %b",
                 i, d[i], e);
      end
    end
    n_cmp++;
    if (IR_OUT !== 4'hA) begin
      n_err++;
      $display("FAIL ircap_ir: got %h expected a", IR_OUT);
    end
  endtask

  task automatic test_user;
    logic [31:0] d, oe;
    logic [15:0] cv = 16'hA55A;
    int base;
    scan(1'b1, 4, 32'h8, d, oe);
    USER_CAP = cv;
    for (int i = 0; i < 16; i++) exp_q.push_back(cv[i]);
    base = stb_cnt;
    scan(1'b0, 16, 32'h1234, d, oe);
    for (int i = 0; i < 16; i++) begin
      logic e = exp_q.pop_front();
      n_cmp++;
      if (d[i] !== e) begin
        n_err++;
        $display("FAIL user_bit%0d: got %b expected %b",
                 i, d[i], e);
      end
    end
    n_cmp++;
    if (USER_UPD !== 16'h1234) begin
      n_err++;
      $display("FAIL user_upd: got %h expected 1234",
               USER_UPD);
    end
    n_cmp++;
    if (stb_cnt - base !== 1) begin
      n_err++;
      $display("FAIL user_stb: got %0d expected 1",
               stb_cnt - base);
    end
  endtask

  task automatic test_reset_abort;
    logic t, o;
    int base = stb_cnt;
    tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    for (int i = 0; i < 7; i++) tck(1'b0, i[0], t, o);
    n_cmp++;
    if (TAP_STATE !== S_SHDR) begin
      n_err++;
      $display("FAIL abort_pre: got %h expected 2",
               TAP_STATE);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) tck(1'b1, 1'b0, t, o);
    n_cmp++;
    if (TAP_STATE !== S_TLR || IR_OUT !== 4'h1) begin
      n_err++;
      $display("FAIL abort_state: got %h/%h expected f/1",
               TAP_STATE, IR_OUT);
    end
    n_cmp++;
    if (USER_UPD !== 16'h0 || stb_cnt != base) begin
      n_err++;
      $display("FAIL abort_upd: got %h/%0d expected 0/0",
               USER_UPD, stb_cnt - base);
    end
    tck(1'b0, 1'b0, t, o);
  endtask

  task automatic test_five_tms;
    logic [31:0] d, oe;
    logic t, o;
    scan(1'b1, 4, 32'hA, d, oe);
    tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    repeat (5) tck(1'b1, 1'b0, t, o);
    n_cmp++;
    if (TAP_STATE !== S_TLR || IR_OUT !== 4'h1) begin
      n_err++;
      $display("FAIL five_tms: got %h/%h expected f/1",
               TAP_STATE, IR_OUT);
    end
    tck(1'b0, 1'b0, t, o);
  endtask

`ifdef NTRST_EN
  task automatic test_ntrst;
    logic [31:0] d, oe;
    logic t, o;
    logic [15:0] upd;
    scan(1'b1, 4, 32'h8, d, oe);
    scan(1'b0, 16, 32'hBEEF, d, oe);
    upd = USER_UPD;
    tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    tck(1'b1, 1'b0, t, o);
    tck(1'b0, 1'b0, t, o);
    n_cmp++;
    if (TAP_STATE !== S_PDR) begin
      n_err++;
      $display("FAIL trst_pre: got %h expected 3", TAP_STATE);
    end
    NTRST_I = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if (TAP_STATE !== S_TLR || IR_OUT !== 4'h1) begin
      n_err++;
      $display("FAIL trst_tlr: got %h/%h expected f/1",
               TAP_STATE, IR_OUT);
    end
    @(negedge CLK);
    NTRST_I = 1'b1;
    repeat (4) @(negedge CLK);
    n_cmp++;
    if (USER_UPD !== 16'hBEEF || upd !== 16'hBEEF) begin
      n_err++;
      $display("FAIL trst_upd: got %h expected beef",
               USER_UPD);
    end
    tck(1'b0, 1'b0, t, o);
  endtask
`endif

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_ir_capture();
    test_user();
    test_reset_abort();
    test_five_tms();
`ifdef NTRST_EN
    test_ntrst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
